// File: rtl/button_pkg.sv
// Shared types and 100 MHz timing defaults for the push-button conditioning path.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned CLK_HZ                = 100_000_000;
    localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;    // 10 ms
    localparam int unsigned DEFAULT_LONG_CYCLES   = 100_000_000;  // 1 s

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (buttons, slide switches).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push-button into level, press pulse and sticky event outputs.
// Optional long-press pulse is built only when BTN_LONG_PRESS_EN is defined.
//
// state        | meaning
// -------------+--------------------------------------------------
// IDLE         | debounced level 0, waiting for a synchronized 1
// PRESS_WAIT   | input high, counting toward acceptance
// PRESSED      | debounced level 1
// RELEASE_WAIT | input low, counting toward release
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic event_ack,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_event,
    output logic btn_long
);

`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    localparam int unsigned MAX_CYCLES =
        (LONG_EN && (LONG_CYCLES > STABLE_CYCLES)) ? LONG_CYCLES : STABLE_CYCLES;
    localparam int unsigned CNT_W = cnt_width(MAX_CYCLES);

    // The sample that moved the FSM out of IDLE/PRESSED already counts as the
    // first stable one, so the wait states accept after STABLE_CYCLES-1 more.
    localparam logic [CNT_W-1:0] STABLE_LAST =
        CNT_W'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);
    localparam bit ACCEPT_FIRST = (STABLE_CYCLES <= 1);

    logic       sync_btn;
    btn_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       pulse_q, pulse_d;
    logic       event_q, event_d;
    logic       stable_done;
    logic       in_wait;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_in),
        .q_o   (sync_btn)
    );

    always_comb begin
        state_d     = state_q;
        pulse_d     = 1'b0;
        stable_done = (cnt_q >= STABLE_LAST);
        in_wait     = (state_q == ST_PRESS_WAIT) || (state_q == ST_RELEASE_WAIT);

        case (state_q)
            ST_IDLE: begin
                if (sync_btn) begin
                    if (ACCEPT_FIRST) begin
                        state_d = ST_PRESSED;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = ST_PRESS_WAIT;
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_btn) begin
                    state_d = ST_IDLE;
                end else if (stable_done) begin
                    state_d = ST_PRESSED;
                    pulse_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync_btn) begin
                    state_d = ACCEPT_FIRST ? ST_IDLE : ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync_btn) begin
                    state_d = ST_PRESSED;
                end else if (stable_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_wait && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
        // Setting on both the transition cycle and the pulse cycle means an ack
        // landing on either of them can never swallow the new press.
        event_d = pulse_d | pulse_q | (event_q & ~event_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            event_q <= event_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign btn_event = event_q;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((LONG_CYCLES >= 1) ? (LONG_CYCLES - 1) : 0);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             fired_q, fired_d;
    logic             long_q, long_d;
    logic             held;

    always_comb begin
        held    = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
        hold_d  = '0;
        long_d  = 1'b0;
        fired_d = 1'b0;
        if (held) begin
            hold_d  = (hold_q != '1) ? (hold_q + 1'b1) : hold_q;
            long_d  = (hold_q == HOLD_LAST) && !fired_q;
            fired_d = fired_q | long_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with STABLE_CYCLES=4, LONG_CYCLES=16.
module tb_button_conditioner;

    localparam int unsigned STABLE = 4;
    localparam int unsigned LONG   = 16;
`ifdef BTN_LONG_PRESS_EN
    localparam logic LX = 1'b1;
`else
    localparam logic LX = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic event_ack;
    logic btn_level;
    logic btn_pulse;
    logic btn_event;
    logic btn_long;
    logic [3:0] outs;

    typedef struct {
        int         cyc;
        logic [3:0] exp;
        logic [3:0] mask;
        string      name;
    } sb_item_t;

    sb_item_t sb[$];

    int cyc        = 0;
    int n_chk      = 0;
    int n_err      = 0;
    int pulse_cnt  = 0;
    int long_cnt   = 0;
    int exp_pulses = 0;
    int exp_longs  = 0;

    button_conditioner #(
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .event_ack (event_ack),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .btn_event (btn_event),
        .btn_long  (btn_long)
    );

    always #5 clk = ~clk;

    assign outs = {btn_level, btn_pulse, btn_event, btn_long};

    task automatic push(input int at, input logic [3:0] e, input logic [3:0] m, input string nm);
        sb_item_t it;
        it.cyc  = at;
        it.exp  = e;
        it.mask = m;
        it.name = nm;
        sb.push_back(it);
    endtask

    task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] e,
                          input logic [3:0] m);
        n_chk++;
        if ((act & m) !== (e & m)) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b (level,pulse,event,long)",
                     nm, cyc, act, e, m);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int e);
        n_chk++;
        if (act != e) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, e);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: counts output pulses and pops expectations due this cycle.
    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (btn_pulse === 1'b1) pulse_cnt++;
            if (btn_long === 1'b1) long_cnt++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                it = sb.pop_front();
                if (it.cyc < cyc) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL %s stale expectation cyc=%0d seen at cyc=%0d",
                             it.name, it.cyc, cyc);
                end else begin
                    check4(it.name, outs, it.exp, it.mask);
                end
            end
        end
    end

    task automatic scen_clean_press();
        int c;
        c = cyc;
        push(c + 5,  4'b0000,                   4'b1111, "a_before_accept");
        push(c + 6,  4'b1110,                   4'b1111, "a_pulse");
        push(c + 7,  4'b1010,                   4'b1111, "a_pulse_one_cycle");
        push(c + 21, 4'b1010,                   4'b1111, "a_long_pre");
        push(c + 22, {1'b1, 1'b0, 1'b1, LX},    4'b1111, "a_long");
        push(c + 23, 4'b1010,                   4'b1111, "a_long_post");
        push(c + 30, 4'b1010,                   4'b1111, "a_ack_cycle");
        push(c + 31, 4'b1000,                   4'b1111, "a_ack_clear");
        push(c + 45, 4'b1000,                   4'b1111, "a_release_hold");
        push(c + 46, 4'b0000,                   4'b1111, "a_release_done");
        exp_pulses += 1;
        exp_longs  += int'(LX);
        btn_in = 1'b1;
        wait_to(c + 30); event_ack = 1'b1;
        wait_to(c + 31); event_ack = 1'b0;
        wait_to(c + 40); btn_in = 1'b0;
        wait_to(c + 50);
    endtask

    task automatic scen_bounce();
        int c;
        c = cyc;
        for (int k = 4; k <= 10; k += 2) push(c + k, 4'b0000, 4'b1111, "b_bounce_quiet");
        btn_in = 1'b1;
        wait_to(c + 1); btn_in = 1'b0;
        wait_to(c + 2); btn_in = 1'b1;
        wait_to(c + 3); btn_in = 1'b0;
        wait_to(c + 12);
    endtask

    task automatic scen_ack_collision();
        int c;
        c = cyc;
        push(c + 6,  4'b1110, 4'b1111, "c_pulse1");
        push(c + 16, 4'b0010, 4'b1111, "c_release_event_held");
        push(c + 26, 4'b1110, 4'b1111, "c_pulse2");
        push(c + 27, 4'b1010, 4'b1111, "c_collision_event");
        push(c + 30, 4'b1010, 4'b1111, "c_before_ack");
        push(c + 31, 4'b1000, 4'b1111, "c_ack_clear");
        push(c + 38, 4'b0000, 4'b1111, "c_release");
        push(c + 41, 4'b0000, 4'b1111, "c_ack_when_clear");
        exp_pulses += 2;
        btn_in = 1'b1;
        wait_to(c + 10); btn_in = 1'b0;
        wait_to(c + 20); btn_in = 1'b1;
        wait_to(c + 26); event_ack = 1'b1;
        wait_to(c + 27); event_ack = 1'b0;
        wait_to(c + 30); event_ack = 1'b1;
        wait_to(c + 31); event_ack = 1'b0;
        wait_to(c + 32); btn_in = 1'b0;
        wait_to(c + 40); event_ack = 1'b1;
        wait_to(c + 41); event_ack = 1'b0;
        wait_to(c + 44);
    endtask

    task automatic scen_release_glitch();
        int c;
        c = cyc;
        push(c + 6, 4'b1110, 4'b1110, "d_pulse");
        for (int k = 11; k <= 17; k++) push(c + k, 4'b1010, 4'b1110, "d_glitch_level_held");
        push(c + 45, 4'b1010, 4'b1110, "d_release_hold");
        push(c + 46, 4'b0010, 4'b1110, "d_release_done");
        exp_pulses += 1;
        exp_longs  += int'(LX);
        btn_in = 1'b1;
        wait_to(c + 10); btn_in = 1'b0;
        wait_to(c + 12); btn_in = 1'b1;
        wait_to(c + 40); btn_in = 1'b0;
        wait_to(c + 50);
    endtask

    task automatic scen_reset_mid_press();
        int c;
        c = cyc;
        push(c + 6,  4'b1110, 4'b1111, "e_pulse");
        push(c + 11, 4'b0000, 4'b1111, "e_reset_hold");
        push(c + 16, 4'b0000, 4'b1111, "e_before_repulse");
        push(c + 17, 4'b1110, 4'b1111, "e_repulse");
        push(c + 18, 4'b1010, 4'b1111, "e_repulse_one_cycle");
        push(c + 30, 4'b0010, 4'b1111, "e_release");
        push(c + 33, 4'b0000, 4'b1111, "e_final_ack");
        exp_pulses += 2;
        btn_in = 1'b1;
        wait_to(c + 10);
        rst_n = 1'b0;
        #1;
        check4("e_reset_immediate", outs, 4'b0000, 4'b1111);
        wait_to(c + 11); rst_n = 1'b1;
        wait_to(c + 24); btn_in = 1'b0;
        wait_to(c + 32); event_ack = 1'b1;
        wait_to(c + 33); event_ack = 1'b0;
        wait_to(c + 36);
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_in    = 1'b0;
        event_ack = 1'b0;
        push(1, 4'b0000, 4'b1111, "reset_outputs_1");
        push(2, 4'b0000, 4'b1111, "reset_outputs_2");
        @(negedge clk);
        wait_to(2);
        rst_n = 1'b1;
        push(4, 4'b0000, 4'b1111, "post_reset_idle");
        wait_to(5);
        scen_clean_press();
        scen_bounce();
        scen_ack_collision();
        scen_release_glitch();
        scen_reset_mid_press();
        wait_to(cyc + 5);
        check_int("pulse_count", pulse_cnt, exp_pulses);
        check_int("long_count", long_cnt, exp_longs);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions one raw push-button input for the counter datapath: two-flop synchronization, counter-based debounce FSM, a one-cycle press pulse, and a sticky press event held until the slow consumer acknowledges it on its divided-clock tick. Sits directly upstream of the ping-pong counter's `flip` and reset-request inputs, with one instance per button.

## Interface
- `STABLE_CYCLES`, default 1_000_000: consecutive synchronized cycles needed to accept a level change (10 ms at 100 MHz).
- `LONG_CYCLES`, default 100_000_000: cycles held in PRESSED before `btn_long` fires (1 s). Used only with `BTN_LONG_PRESS_EN`.
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_in` in 1: raw, asynchronous, bouncing button level (1 = pressed).
- `event_ack` in 1: one-cycle consumer strobe, typically the divider tick, that clears `btn_event`.
- `btn_level` out 1: debounced level.
- `btn_pulse` out 1: one-cycle pulse on each accepted press.
- `btn_event` out 1: sticky press flag, held until acknowledged.
- `btn_long` out 1: one-cycle long-press pulse, at most one per press.

## Operation
- Synchronizer: 2 flops, both reset to 0. `sync_q` is the second flop.
- FSM states and transitions. The stability counter `cnt` clears on every state change.
  - IDLE: `sync_q`=1 → PRESS_WAIT.
  - PRESS_WAIT: `sync_q`=0 → IDLE (glitch rejected). `cnt` reaches STABLE_CYCLES-1 with `sync_q`=1 → PRESSED.
  - PRESSED: `sync_q`=0 → RELEASE_WAIT.
  - RELEASE_WAIT: `sync_q`=1 → PRESSED (no new pulse). `cnt` reaches STABLE_CYCLES-1 with `sync_q`=0 → IDLE.
- `btn_level` = 1 in PRESSED and RELEASE_WAIT, registered.
- `btn_pulse`: registered, high for exactly the one cycle after the PRESS_WAIT→PRESSED transition.
- `btn_event`:
  - set by `btn_pulse`;
  - cleared on a cycle with `event_ack`=1;
  - if set and ack occur in the same cycle, set wins, so no press is ever lost;
  - ack while the flag is clear has no effect.
- Counter width is `$clog2` of the larger active parameter. The counter saturates and never wraps.
- Reset: all outputs are 0, FSM is in IDLE, counters and synchronizer are 0. Asserting reset mid-press drops any pending event. After release, a button still held produces a fresh press (pulse) once stable.
- STABLE_CYCLES ≥ 1 is required. STABLE_CYCLES = 1 accepts on the first synchronized sample.

## Timing
- `btn_in` rises before edge 0 and stays stable → `sync_q` = 1 after edge 1 → `btn_pulse` and `btn_level` rise after edge STABLE_CYCLES+1. The press latency is therefore STABLE_CYCLES+2 edges, counting edge 0.
- Release latency to `btn_level`=0 is the same, STABLE_CYCLES+2.
- `btn_event` rises in the same cycle as `btn_pulse`. With ack it falls one edge later.
- A bounce shorter than STABLE_CYCLES synchronized cycles produces no output change.

## Configuration
- `BTN_LONG_PRESS_EN` defined:
  - a hold counter runs in PRESSED and RELEASE_WAIT and clears on entry to IDLE;
  - `btn_long` pulses for one cycle after the hold counter reaches LONG_CYCLES-1;
  - `btn_long` does not fire again until the next accepted press.
- Not defined:
  - the hold counter logic is absent;
  - `btn_long` is tied to 0;
  - `LONG_CYCLES` is ignored.

## Structure
- Shared package `button_pkg` holds:
  - the FSM state typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, 2-bit encoding);
  - default timing constants for a 100 MHz clock.
- Sub-module `sync_2ff` implements the 2-flop synchronizer with asynchronous active-low reset. It is reused for the slide-switch inputs.

## Test plan
All scenarios use STABLE_CYCLES=4 and LONG_CYCLES=16.
- Clean press: `btn_in` 0→1 before edge 0 → `btn_pulse` high only after edge 5, `btn_level`=1 from edge 5, `btn_event`=1 until `event_ack`.
- Bounce: `btn_in` toggles 1,0,1,0 on successive cycles, then stays 0 → `btn_level`, `btn_pulse` and `btn_event` remain 0.
- Ack collision: `event_ack` is pulsed in the same cycle as a second `btn_pulse` → `btn_event` stays 1. A following ack with no press → 0 one edge later.
- Release glitch: while PRESSED, `btn_in`=0 for 2 cycles then 1 → `btn_level` stays 1, no second `btn_pulse`.
- Long press (with `BTN_LONG_PRESS_EN`): hold for 40 cycles → exactly one `btn_long` pulse, 16 edges after `btn_pulse`. Without the macro, `btn_long` stays 0.
- Reset mid-press: `rst_n`=0 while `btn_event`=1 → all outputs 0 immediately. Release `rst_n` with the button held → new `btn_pulse` 6 edges later.
